nibble_deserializer: RTL and testbench

- Serial-to-parallel front end that assembles a WIDTH-bit word from a 1-bit stream with start marker and valid qualifier.
- Sits directly upstream of the 4-bit D-register stage: word_out drives the register's D input, and word_valid marks the cycle in which D carries a fresh word.
- Also reports framing errors and busy status to the surrounding control logic.

---
 rtl/nibble_deserializer.sv | 210 +++++++++++++++++++++
 tb/tb_nibble_deserializer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_deserializer.sv
// -----------------------------------------------------------------------------
// nibble_deserializer
//
// Serial-to-parallel front end. It assembles a WIDTH-bit word from a 1-bit
// stream that is qualified by sin_valid and framed by sin_start. The completed
// word is presented on word_out, which feeds the D input of the downstream
// register stage. word_valid marks the single cycle in which word_out carries
// a freshly completed word.
//
// Parameters:
//   WIDTH      bits per word, 2..16
//   MSB_FIRST  1: the first serial bit lands in word_out[WIDTH-1]
//              0: the first serial bit lands in word_out[0]
//
// Optional feature (compile-time macro NIBBLE_DESER_PARITY_EN):
//   When the macro is defined, each frame carries a trailing even-parity bit.
//   A parity mismatch drops the word, pulses parity_err and sets frame_err.
//   When the macro is undefined, frames are WIDTH bits long, parity_err is
//   tied low and no parity logic exists.
//
// Ports:
//   clk         clock; all state updates on the rising edge
//   rst         asynchronous, active-high reset
//   sin_data    serial data bit
//   sin_valid   sin_data is valid this cycle; bits are consumed only when high
//   sin_start   qualified by sin_valid; marks bit 0 of a frame
//   err_clr     clears frame_err (a simultaneous new error wins)
//   word_out    last completed word; holds between completions
//   word_valid  one-cycle pulse: word_out was updated this cycle
//   busy        high while a frame is partially received
//   frame_err   sticky framing-error flag
//   parity_err  one-cycle pulse on a parity mismatch
// -----------------------------------------------------------------------------
module nibble_deserializer #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_data,
  input  logic             sin_valid,
  input  logic             sin_start,
  input  logic             err_clr,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err
);

`ifdef NIBBLE_DESER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  localparam int FRAME_LEN = WIDTH + PARITY_BITS;
  localparam int CW        = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg,     state_next;
  logic [CW-1:0]    count_reg,     count_next;
  logic [WIDTH-1:0] shift_reg,     shift_next;
  logic [WIDTH-1:0] word_out_reg,  word_out_next;
  logic             word_vld_reg,  word_vld_next;
  logic             frame_err_reg, frame_err_next;

  // Shift source: a new frame always starts from an all-zero register so no
  // bits of an earlier or aborted frame can leak into the assembled word.
  logic [WIDTH-1:0] shift_base;
  logic [WIDTH-1:0] shifted;
  logic             last_bit;

  assign shift_base = ((state_reg == IDLE) || sin_start) ? '0 : shift_reg;
  assign last_bit   = (count_reg == LAST_IDX);

  // Bit-order selection. MSB-first shifts left so the first bit ends up in
  // the top position after WIDTH shifts; LSB-first shifts right so the first
  // bit ends up in bit 0.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shifted = (shift_base << 1) | {{(WIDTH-1){1'b0}}, sin_data};
    end else begin : g_lsb_first
      assign shifted = (shift_base >> 1) | {sin_data, {(WIDTH-1){1'b0}}};
    end
  endgenerate

`ifdef NIBBLE_DESER_PARITY_EN
  logic parity_err_reg, parity_err_next;
  logic parity_ok;

  // When the parity bit arrives the shift register already holds all WIDTH
  // data bits; even parity means the XOR over data and parity bit is zero.
  assign parity_ok = ~(^shift_reg ^ sin_data);
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      shift_reg     <= '0;
      word_out_reg  <= '0;
      word_vld_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
`ifdef NIBBLE_DESER_PARITY_EN
      parity_err_reg <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      shift_reg     <= shift_next;
      word_out_reg  <= word_out_next;
      word_vld_reg  <= word_vld_next;
      frame_err_reg <= frame_err_next;
`ifdef NIBBLE_DESER_PARITY_EN
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    shift_next     = shift_reg;
    word_out_next  = word_out_reg;
    word_vld_next  = 1'b0;
    frame_err_next = frame_err_reg;
`ifdef NIBBLE_DESER_PARITY_EN
    parity_err_next = 1'b0;
`endif

    // Clear first so that any error detected below in the same cycle wins.
    if (err_clr) begin
      frame_err_next = 1'b0;
    end

    if (sin_valid) begin
      case (state_reg)
        IDLE: begin
          if (sin_start) begin
            shift_next = shifted;
            count_next = ONE;
            state_next = SHIFT;
          end else begin
            // Stray bit outside a frame: dropped and flagged.
            frame_err_next = 1'b1;
          end
        end

        SHIFT: begin
          if (sin_start) begin
            // Premature start: abandon the partial word and restart the
            // frame with this bit. word_out is left untouched.
            shift_next     = shifted;
            count_next     = ONE;
            frame_err_next = 1'b1;
          end else if (last_bit) begin
`ifdef NIBBLE_DESER_PARITY_EN
            // Final bit is the parity bit; it never enters the data word.
            if (parity_ok) begin
              word_out_next = shift_reg;
              word_vld_next = 1'b1;
            end else begin
              parity_err_next = 1'b1;
              frame_err_next  = 1'b1;
            end
`else
            word_out_next = shifted;
            word_vld_next = 1'b1;
`endif
            shift_next = '0;
            count_next = '0;
            state_next = IDLE;
          end else begin
            shift_next = shifted;
            count_next = count_reg + ONE;
          end
        end

        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  assign word_out   = word_out_reg;
  assign word_valid = word_vld_reg;
  assign busy       = (state_reg == SHIFT);
  assign frame_err  = frame_err_reg;
`ifdef NIBBLE_DESER_PARITY_EN
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_deserializer.sv
module tb_nibble_deserializer;
  localparam int W = 4;
`ifdef NIBBLE_DESER_PARITY_EN
  localparam int FLEN = W + 1;
`else
  localparam int FLEN = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sin_data = 1'b0, sin_valid = 1'b0, sin_start = 1'b0, err_clr = 1'b0;
  logic [W-1:0] word_msb, word_lsb;
  logic wv_msb, busy_msb, ferr_msb, perr_msb;
  logic wv_lsb, busy_lsb, ferr_lsb, perr_lsb;

  always #5 clk = ~clk;

  nibble_deserializer #(.WIDTH(W), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .sin_data(sin_data), .sin_valid(sin_valid),
    .sin_start(sin_start), .err_clr(err_clr), .word_out(word_msb),
    .word_valid(wv_msb), .busy(busy_msb), .frame_err(ferr_msb),
    .parity_err(perr_msb)
  );

  nibble_deserializer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .sin_data(sin_data), .sin_valid(sin_valid),
    .sin_start(sin_start), .err_clr(err_clr), .word_out(word_lsb),
    .word_valid(wv_lsb), .busy(busy_lsb), .frame_err(ferr_lsb),
    .parity_err(perr_lsb)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: collects the bits of the current frame in a queue and
  // builds the word from bit positions once the frame is complete.
  bit           mq[$];
  bit           m_in_frame;
  logic [W-1:0] m_wm, m_wl;
  bit           m_wv, m_ferr, m_perr;

  typedef struct {
    logic [W-1:0] b;    // b[W-1] is serial bit 0
    logic [W-1:0] msb;  // expected word, MSB-first instance
    logic [W-1:0] lsb;  // expected word, LSB-first instance
  } vec_t;

  vec_t tbl[6];

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_in_frame = 0;
    m_wm = '0; m_wl = '0;
    m_wv = 0; m_ferr = 0; m_perr = 0;
  endtask

  task automatic model_step(bit v, bit s, bit d, bit c);
    int ones;
    m_wv = 0;
    m_perr = 0;
    if (c) m_ferr = 0;
    if (v) begin
      if (s) begin
        if (m_in_frame) m_ferr = 1;
        mq.delete();
        mq.push_back(d);
        m_in_frame = 1;
      end else if (!m_in_frame) begin
        m_ferr = 1;
      end else begin
        mq.push_back(d);
        if (mq.size() == FLEN) begin
          ones = 0;
          foreach (mq[i]) ones += int'(mq[i]);
          if (FLEN > W && (ones % 2) != 0) begin
            m_perr = 1;
            m_ferr = 1;
          end else begin
            m_wv = 1;
            for (int i = 0; i < W; i++) begin
              m_wm[W-1-i] = mq[i];
              m_wl[i]     = mq[i];
            end
          end
          mq.delete();
          m_in_frame = 0;
        end
      end
    end
  endtask

  task automatic compare_all(string tag);
    check({tag, ".word_msb"}, 16'(word_msb), 16'(m_wm));
    check({tag, ".word_lsb"}, 16'(word_lsb), 16'(m_wl));
    check({tag, ".wv_msb"},   16'(wv_msb),   16'(m_wv));
    check({tag, ".wv_lsb"},   16'(wv_lsb),   16'(m_wv));
    check({tag, ".busy"},     16'(busy_msb), 16'(m_in_frame));
    check({tag, ".busy_lsb"}, 16'(busy_lsb), 16'(m_in_frame));
    check({tag, ".ferr"},     16'(ferr_msb), 16'(m_ferr));
    check({tag, ".perr"},     16'(perr_msb), 16'(m_perr));
  endtask

  task automatic cycle(string tag, bit v, bit s, bit d, bit c);
    sin_valid = v; sin_start = s; sin_data = d; err_clr = c;
    @(posedge clk);
    model_step(v, s, d, c);
    #1;
    compare_all(tag);
    $display("cycle %-8s v=%0b s=%0b d=%0b clr=%0b -> wv=%0b word=%h/%h busy=%0b ferr=%0b perr=%0b",
             tag, v, s, d, c, wv_msb, word_msb, word_lsb, busy_msb, ferr_msb, perr_msb);
  endtask

  // Sends one frame (plus even parity when enabled), with 'stall' invalid
  // cycles between consecutive bits.
  task automatic send_frame(string tag, logic [W-1:0] b, int stall);
    bit d;
    for (int i = 0; i < FLEN; i++) begin
      d = (i < W) ? b[W-1-i] : ^b;
      cycle(tag, 1'b1, i == 0, d, 1'b0);
      if (i < FLEN - 1) begin
        repeat (stall) cycle(tag, 1'b0, 1'b0, 1'($urandom % 2), 1'b0);
      end
    end
  endtask

  initial begin
    tbl[0] = '{b: 4'b1011, msb: 4'hB, lsb: 4'hD};
    tbl[1] = '{b: 4'b0110, msb: 4'h6, lsb: 4'h6};
    tbl[2] = '{b: 4'b1111, msb: 4'hF, lsb: 4'hF};
    tbl[3] = '{b: 4'b0011, msb: 4'h3, lsb: 4'hC};
    tbl[4] = '{b: 4'b1001, msb: 4'h9, lsb: 4'h9};
    tbl[5] = '{b: 4'b1000, msb: 4'h8, lsb: 4'h1};

    // Reset state
    rst = 1'b1;
    #3;
    model_reset();
    compare_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Table-driven frames with fixed expected words
    for (int i = 0; i < 6; i++) begin
      send_frame("tbl", tbl[i].b, 0);
      check("tbl.wv",  16'(wv_msb),   16'd1);
      check("tbl.msb", 16'(word_msb), 16'(tbl[i].msb));
      check("tbl.lsb", 16'(word_lsb), 16'(tbl[i].lsb));
      cycle("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of a frame
    cycle("prerst", 1'b1, 1'b1, 1'b1, 1'b0);
    cycle("prerst", 1'b1, 1'b0, 1'b0, 1'b0);
    check("mid.busy", 16'(busy_msb), 16'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst");
    check("async_rst.word", 16'(word_msb), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    send_frame("afterrst", 4'b1011, 0);
    check("afterrst.word", 16'(word_msb), 16'hB);
    cycle("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check("afterrst.single_pulse", 16'(wv_msb), 16'd0);

    // Stalls between bits
    send_frame("stall", 4'b0110, 3);
    check("stall.word", 16'(word_msb), 16'h6);
    check("stall.wv",   16'(wv_msb),   16'd1);

    // Back-to-back frames, no bubble
    send_frame("b2b", 4'b1111, 0);
    check("b2b.first", 16'(word_msb), 16'hF);
    send_frame("b2b", 4'b0011, 0);
    check("b2b.second", 16'(word_msb), 16'h3);
    check("b2b.wv",     16'(wv_msb),   16'd1);

    // Premature start, then err_clr
    cycle("prem", 1'b1, 1'b1, 1'b0, 1'b0);
    cycle("prem", 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame("prem", 4'b1001, 0);
    check("prem.ferr", 16'(ferr_msb), 16'd1);
    check("prem.word", 16'(word_msb), 16'h9);
    cycle("clr", 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr.ferr", 16'(ferr_msb), 16'd0);

    // Stray bit in IDLE, then LSB-first frame
    cycle("stray", 1'b1, 1'b0, 1'b1, 1'b0);
    check("stray.ferr", 16'(ferr_msb), 16'd1);
    check("stray.wv",   16'(wv_msb),   16'd0);
    cycle("clr", 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame("lsb", 4'b1000, 0);
    check("lsb.word", 16'(word_lsb), 16'h1);

    // Clear and new error in the same cycle: set wins
    cycle("clrset", 1'b1, 1'b0, 1'b0, 1'b1);
    check("clrset.ferr", 16'(ferr_msb), 16'd1);
    cycle("clr", 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef NIBBLE_DESER_PARITY_EN
    // Good parity, then bad parity
    send_frame("par_ok", 4'b1011, 0);
    check("par_ok.word", 16'(word_msb), 16'hB);
    check("par_ok.wv",   16'(wv_msb),   16'd1);
    cycle("par_bad", 1'b1, 1'b1, 1'b1, 1'b0);
    cycle("par_bad", 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("par_bad", 1'b1, 1'b0, 1'b1, 1'b0);
    cycle("par_bad", 1'b1, 1'b0, 1'b1, 1'b0);
    cycle("par_bad", 1'b1, 1'b0, 1'b0, 1'b0);
    check("par_bad.perr", 16'(perr_msb), 16'd1);
    check("par_bad.wv",   16'(wv_msb),   16'd0);
    check("par_bad.word", 16'(word_msb), 16'hB);
    check("par_bad.ferr", 16'(ferr_msb), 16'd1);
    cycle("clr", 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      cycle("rand", ($urandom % 4) != 0, ($urandom % 6) == 0,
            1'($urandom % 2), ($urandom % 16) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
